// File: rtl/cep_loop_seq_pkg.sv
// Shared definitions for the cepstral nested-loop sequencer.
package cep_loop_seq_pkg;

   // Sequencer FSM encoding
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } cep_state_t;

   localparam int unsigned IDX_W_DEF = 7;

   // MFCC defaults: 13 cepstral coefficients over 26 mel filters
   localparam int unsigned NUM_CEP_LAST  = 12;
   localparam int unsigned NUM_FILT_LAST = 25;

endpackage

// File: rtl/cep_loop_cnt.sv
// Single loop counter: counts 0..last, flags the last value and wraps on enable.
module cep_loop_cnt
   import cep_loop_seq_pkg::*;
#(
   parameter int unsigned IDX_W = IDX_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   input  logic [IDX_W-1:0] last,
   output logic [IDX_W-1:0] count,
   output logic             over
);

   logic [IDX_W-1:0] count_q;

   assign count = count_q;
   assign over  = (count_q == last);

   // Counter register; clear wins over enable, wrap happens only through the last-compare
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (en) begin
         count_q <= over ? '0 : count_q + 1'b1;
      end
   end

endmodule

// File: rtl/cep_loop_seq.sv
// Nested (coefficient, filter) loop sequencer feeding the cepstral MAC over valid/ready.
module cep_loop_seq
   import cep_loop_seq_pkg::*;
#(
   parameter int unsigned IDX_W = IDX_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [IDX_W-1:0] cfg_coef_last,
   input  logic [IDX_W-1:0] cfg_filt_last,
   output logic             busy,
   output logic             done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_coef_idx,
   output logic [IDX_W-1:0] out_filt_idx,
   output logic             out_first,
   output logic             out_last_filt,
   output logic             out_last
);

   cep_state_t       state_q, state_d;
   logic [IDX_W-1:0] coef_last_q, filt_last_q;
   logic [IDX_W-1:0] coef_idx, filt_idx;
   logic             coef_over, filt_over;
   logic             start_acc, handshake, advance;

   assign start_acc = (state_q == StIdle) & start & ~abort;
   assign handshake = out_valid & out_ready;
   // An aborted beat is consumed downstream but must not move the indices
   assign advance   = handshake & ~abort;

   cep_loop_cnt #(
      .IDX_W (IDX_W)
   ) u_filt_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (start_acc),
      .en    (advance),
      .last  (filt_last_q),
      .count (filt_idx),
      .over  (filt_over)
   );

   cep_loop_cnt #(
      .IDX_W (IDX_W)
   ) u_coef_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (start_acc),
      .en    (advance & filt_over),
      .last  (coef_last_q),
      .count (coef_idx),
      .over  (coef_over)
   );

   // State and latched loop bounds
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         coef_last_q <= '0;
         filt_last_q <= '0;
      end else begin
         state_q <= state_d;
         if (start_acc) begin
            coef_last_q <= cfg_coef_last;
            filt_last_q <= cfg_filt_last;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (start_acc) state_d = StRun;
         StRun: begin
            if (abort) begin
               state_d = StIdle;
            end else if (handshake & filt_over & coef_over) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from state and indices; flags qualified by valid
   always_comb begin
      busy          = (state_q == StRun) | (state_q == StDone);
      done          = (state_q == StDone);
      out_valid     = (state_q == StRun);
      out_coef_idx  = coef_idx;
      out_filt_idx  = filt_idx;
      out_first     = out_valid & (filt_idx == '0);
      out_last_filt = out_valid & filt_over;
      out_last      = out_valid & filt_over & coef_over;
   end

endmodule

// File: tb/tb_cep_loop_seq.sv
// Randomised self-checking bench for cep_loop_seq against a pair-list reference model.
module tb_cep_loop_seq;

   localparam int unsigned W = 7;

   logic         clk = 1'b0;
   logic         rst;
   logic         start, abort, out_ready;
   logic [W-1:0] cfg_coef_last, cfg_filt_last;
   logic         busy, done, out_valid, out_first, out_last_filt, out_last;
   logic [W-1:0] out_coef_idx, out_filt_idx;

   int total = 0;
   int bad   = 0;

   cep_loop_seq #(
      .IDX_W (W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .cfg_coef_last (cfg_coef_last),
      .cfg_filt_last (cfg_filt_last),
      .busy          (busy),
      .done          (done),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_coef_idx  (out_coef_idx),
      .out_filt_idx  (out_filt_idx),
      .out_first     (out_first),
      .out_last_filt (out_last_filt),
      .out_last      (out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_flags"}, {out_first, out_last_filt, out_last}, 0);
   endtask

   // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready.
   // noise: pulse start and scramble cfg while the frame runs.
   task automatic run_frame(input int c_last, input int f_last, input int mode, input bit noise);
      int qc[$];
      int qf[$];
      int k;
      int beats;
      for (int c = 0; c <= c_last; c++)
         for (int f = 0; f <= f_last; f++) begin
            qc.push_back(c);
            qf.push_back(f);
         end
      chk("pre_start_busy", busy, 0);
      cfg_coef_last = W'(c_last);
      cfg_filt_last = W'(f_last);
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      beats = 0;
      while (qc.size() != 0 && k < 3000) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (k % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (noise) begin
            start         = 1'($urandom_range(0, 1));
            cfg_coef_last = W'($urandom);
            cfg_filt_last = W'($urandom);
         end
         chk("run_valid", out_valid, 1);
         chk("run_busy", busy, 1);
         chk("run_done", done, 0);
         chk("run_coef", out_coef_idx, qc[0]);
         chk("run_filt", out_filt_idx, qf[0]);
         chk("run_first", out_first, qf[0] == 0);
         chk("run_last_filt", out_last_filt, qf[0] == f_last);
         chk("run_last", out_last, qc.size() == 1);
         if (out_valid !== 1'b1) begin
            k = 3000;
         end else begin
            tick();
            if (out_ready) begin
               void'(qc.pop_front());
               void'(qf.pop_front());
               beats++;
            end
            k++;
         end
      end
      start     = 1'b0;
      out_ready = 1'b0;
      chk("frame_beats", beats, (c_last + 1) * (f_last + 1));
      chk("done_pulse", done, 1);
      chk("done_valid", out_valid, 0);
      chk("done_busy", busy, 1);
      chk("done_flags", {out_first, out_last_filt, out_last}, 0);
      tick();
      chk_idle("post_done");
   endtask

   initial begin
      rst           = 1'b1;
      start         = 1'b0;
      abort         = 1'b0;
      out_ready     = 1'b0;
      cfg_coef_last = '0;
      cfg_filt_last = '0;
      tick();
      tick();
      chk_idle("reset");
      chk("reset_idx", {out_coef_idx, out_filt_idx}, 0);
      #3 rst = 1'b0;
      tick();
      chk_idle("after_reset");

      // Basic 2x3 frame, no stalls
      run_frame(1, 2, 0, 1'b0);
      // Same with 1,0,0 ready pattern
      run_frame(1, 2, 1, 1'b0);
      // Default MFCC config, then with random backpressure and start/cfg noise
      run_frame(12, 25, 0, 1'b0);
      run_frame(12, 25, 2, 1'b1);
      // Degenerate single-beat frame
      run_frame(0, 0, 0, 1'b0);
      run_frame(0, 0, 2, 1'b1);
      // A few random small configs
      for (int i = 0; i < 4; i++)
         run_frame(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 2, 1'b1);

      // Abort after three beats, coinciding with a handshake
      cfg_coef_last = 7'd12;
      cfg_filt_last = 7'd25;
      start = 1'b1;
      tick();
      start     = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("abort_pre_filt", out_filt_idx, 3);
      abort = 1'b1;
      tick();
      abort     = 1'b0;
      out_ready = 1'b0;
      chk_idle("abort");
      tick();
      chk_idle("abort_hold");
      run_frame(0, 1, 0, 1'b0);

      // Asynchronous reset mid-frame
      cfg_coef_last = 7'd3;
      cfg_filt_last = 7'd4;
      start = 1'b1;
      tick();
      start     = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("prereset_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      chk_idle("async_reset");
      chk("async_reset_idx", {out_coef_idx, out_filt_idx}, 0);
      #1 rst = 1'b0;
      out_ready = 1'b0;
      tick();
      chk_idle("after_async_reset");
      run_frame(2, 1, 2, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cep_loop_seq.md
# cep_loop_seq

Nested-loop sequencer that drives the cepstral (DCT) stage of the MFCC pipeline. It generates every (coefficient, filter) index pair over a valid/ready stream and marks the accumulation boundaries for each pair. It owns the loop enables and consumes the wrap ("over") condition of two internal loop counters, so the downstream MAC/LUT logic only needs to follow the stream. It sits between the MFCC top-level control (start/done) and the cepstral coefficient MAC datapath.

## Interface
- IDX_W, 7, width of both loop indices and config values
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  start pulse; honoured only in IDLE
- abort  in  1  synchronous abort; returns the block to IDLE with no done
- cfg_coef_last  in  IDX_W  last coefficient index (inclusive); sampled on accepted start
- cfg_filt_last  in  IDX_W  last filter index (inclusive); sampled on accepted start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse after the final pair is transferred
- out_valid  out  1  index pair available
- out_ready  in  1  downstream accepts the pair
- out_coef_idx  out  IDX_W  current coefficient index
- out_filt_idx  out  IDX_W  current filter index
- out_first  out  1  out_filt_idx == 0 (clear accumulator)
- out_last_filt  out  1  out_filt_idx == filt_last (write coefficient)
- out_last  out  1  final pair of the frame

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: on start with abort low:
  - latch cfg_coef_last and cfg_filt_last into coef_last and filt_last;
  - clear both indices to 0;
  - go to RUN.
- RUN: out_valid = 1. A handshake (out_valid & out_ready) advances the indices:
  - filt_idx != filt_last: filt_idx+1.
  - filt_idx == filt_last, coef_idx != coef_last: filt_idx <- 0, coef_idx+1.
  - both indices at their last value: go to DONE. Indices hold their values.
- No handshake: all outputs hold.
- DONE: done = 1 for exactly one cycle, then IDLE.
- abort (any state) returns to IDLE next cycle, with out_valid low and no done.
  - If abort coincides with a handshake, the consumer has taken that beat; only the FSM state changes.
- start outside IDLE is ignored. Changes to the cfg inputs while busy are ignored.
- Beats per frame: (coef_last+1)·(filt_last+1). With both cfg values 0 the frame is a single beat, with out_first = out_last_filt = out_last = 1.
- Index arithmetic is unsigned, IDX_W bits. The counters never exceed their latched last value, so wrap occurs only through the last-compare.
- Flag outputs decode from the indices and are qualified by out_valid. All flags are 0 outside RUN.

## Timing
- Reset values: busy, done, out_valid, out_first, out_last_filt, out_last = 0; out_coef_idx, out_filt_idx = 0.
- start accepted in cycle T: out_valid = 1 with pair (0,0) in T+1.
- With out_ready held high: one pair per cycle, no bubbles, including across the coefficient wrap.
- Last handshake in cycle L: done = 1 and out_valid = 0 in L+1; IDLE in L+2. Earliest next accepted start is L+2.
- out_valid never drops in RUN without a handshake (AXI-style). Indices are stable while valid & !ready.
- Reset asserted mid-frame: immediate IDLE, all outputs at their reset values.

## Structure
- Shared package holds:
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default IDX_W;
  - the MFCC defaults NUM_CEP_LAST=12 and NUM_FILT_LAST=25.
- One sub-module, cep_loop_cnt, instantiated twice (filter loop and coefficient loop):
  - inputs: enable, last value, clear;
  - outputs: count and an over flag (count == last);
  - on enable at over, wraps to 0.
- The parent generates the enables:
  - filter enable = handshake;
  - coefficient enable = handshake & filt_over;
  - DONE transition = handshake & filt_over & coef_over.

## Test plan
- Reset, then coef_last=1, filt_last=2, ready held high, start -> 6 beats (0,0)(0,1)(0,2)(1,0)(1,1)(1,2) on consecutive cycles:
  - out_first on beats 1 and 4, out_last_filt on beats 3 and 6, out_last on beat 6;
  - done exactly 1 cycle after beat 6.
- Same config with out_ready toggled 1,0,0,1,… -> identical index sequence, indices stable during stall cycles, no duplicated or dropped pair.
- Default config 12/25 -> 338 beats, final pair (12,25), done once, busy low 2 cycles after the last beat.
- Both cfg values 0 -> single beat (0,0) with all three flags high, then done.
- abort after beat 3 of the 12/25 config, then start with 0/1 -> no done for the aborted frame; new frame emits (0,0)(0,1) and done.
- start pulsed while busy, plus cfg changed mid-frame -> frame unaffected. Async reset asserted mid-frame -> all outputs 0 within the same cycle.
